alarm_fsm: RTL and testbench

//  Anti-theft controller directly upstream of the countdown timer. Decides which

---
 rtl/alarm_pkg.sv | 32 +++
 rtl/time_params.sv | 36 +++
 rtl/alarm_fsm.sv | 172 +++++++++++++++++
 tb/tb_alarm_fsm.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the anti-theft alarm controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    ARMED       = 3'd0,
    TRIGGERED   = 3'd1,
    SOUND_ALARM = 3'd2,
    ALARM_HOLD  = 3'd3,
    DISARMED    = 3'd4,
    DOOR_OPEN   = 3'd5,
    ARM_DELAY   = 3'd6
  } state_t;

  typedef logic [3:0] interval_t;
  typedef logic [1:0] param_idx_t;

  localparam param_idx_t P_ARM = 2'd0;
  localparam param_idx_t P_DRV = 2'd1;
  localparam param_idx_t P_PAS = 2'd2;
  localparam param_idx_t P_ALM = 2'd3;

  localparam interval_t T_ARM_DEF = 4'd6;
  localparam interval_t T_DRV_DEF = 4'd8;
  localparam interval_t T_PAS_DEF = 4'd15;
  localparam interval_t T_ALM_DEF = 4'd10;

  // A zero interval would never expire, so the smallest storable value is 1.
  function automatic interval_t clamp_interval(input interval_t v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

endpackage

// File: rtl/time_params.sv
// Four programmable timer intervals with reset defaults, one clamped write
// port and one combinational read port.
module time_params
  import alarm_pkg::*;
#(
  parameter interval_t T_ARM = T_ARM_DEF,
  parameter interval_t T_DRV = T_DRV_DEF,
  parameter interval_t T_PAS = T_PAS_DEF,
  parameter interval_t T_ALM = T_ALM_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       wr_en_i,
  input  param_idx_t wr_sel_i,
  input  interval_t  wr_val_i,
  input  param_idx_t rd_sel_i,
  output interval_t  rd_val_o
);

  interval_t param_q [4];

  // Register file: defaults on reset, clamped write when enabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      param_q[P_ARM] <= T_ARM;
      param_q[P_DRV] <= T_DRV;
      param_q[P_PAS] <= T_PAS;
      param_q[P_ALM] <= T_ALM;
    end else if (wr_en_i) begin
      param_q[wr_sel_i] <= clamp_interval(wr_val_i);
    end
  end

  assign rd_val_o = param_q[rd_sel_i];

endmodule

// File: rtl/alarm_fsm.sv
// Anti-theft controller: sequences the countdown timer, drives siren,
// status LED and fuel-pump enable.
//
// state       | meaning
// ARMED       | armed, LED blinks at 1 Hz, waiting for a door
// TRIGGERED   | door opened while armed, waiting for ignition or timeout
// SOUND_ALARM | siren on, waiting for both doors to close
// ALARM_HOLD  | siren on, doors closed, hold time running
// DISARMED    | owner present (ignition seen)
// DOOR_OPEN   | disarmed, ignition off, driver door open
// ARM_DELAY   | driver door closed, arming delay running
module alarm_fsm
  import alarm_pkg::*;
#(
  parameter interval_t T_ARM_DEF = alarm_pkg::T_ARM_DEF,
  parameter interval_t T_DRV_DEF = alarm_pkg::T_DRV_DEF,
  parameter interval_t T_PAS_DEF = alarm_pkg::T_PAS_DEF,
  parameter interval_t T_ALM_DEF = alarm_pkg::T_ALM_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ignition,
  input  logic       door_driver,
  input  logic       door_pass,
  input  logic       hidden_sw,
  input  logic       brake,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic       expired_pulse,
  input  logic       one_hz,
  output logic       start_timer,
  output logic [3:0] value,
  output logic       siren,
  output logic       status_led,
  output logic       fuel_pump,
  output logic [2:0] state_out
);

  state_t     state_q, state_d;
  logic       start_q, start_d;
  interval_t  value_q;
  logic       siren_q, siren_d;
  logic       led_q, led_d;
  logic       pump_q, pump_d;
  logic       live_q, live_d;
  param_idx_t sel_d;
  interval_t  sel_val;
  logic       exp_ok;
  logic       door_any;

  time_params #(
    .T_ARM(T_ARM_DEF),
    .T_DRV(T_DRV_DEF),
    .T_PAS(T_PAS_DEF),
    .T_ALM(T_ALM_DEF)
  ) u_params (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_en_i  (reprogram),
    .wr_sel_i (time_param_sel),
    .wr_val_i (time_value),
    .rd_sel_i (sel_d),
    .rd_val_o (sel_val)
  );

  // An expiry only counts for a count we started, and never in its start cycle.
  assign exp_ok   = expired_pulse && live_q && !start_q;
  assign door_any = door_driver || door_pass;

  // Next state, timer start request and interval selection.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    sel_d   = P_ARM;
    if (reprogram) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          if (door_driver) begin
            state_d = TRIGGERED;
            start_d = 1'b1;
            sel_d   = P_DRV;
          end else if (door_pass) begin
            state_d = TRIGGERED;
            start_d = 1'b1;
            sel_d   = P_PAS;
          end
        end
        TRIGGERED: begin
          if (ignition)    state_d = DISARMED;
          else if (exp_ok) state_d = SOUND_ALARM;
        end
        SOUND_ALARM: begin
          if (ignition) begin
            state_d = DISARMED;
          end else if (!door_any) begin
            state_d = ALARM_HOLD;
            start_d = 1'b1;
            sel_d   = P_ALM;
          end
        end
        ALARM_HOLD: begin
          if (ignition)      state_d = DISARMED;
          else if (door_any) state_d = SOUND_ALARM;
          else if (exp_ok)   state_d = ARMED;
        end
        DISARMED: begin
          if (!ignition && door_driver) state_d = DOOR_OPEN;
        end
        DOOR_OPEN: begin
          if (ignition) begin
            state_d = DISARMED;
          end else if (!door_driver) begin
            state_d = ARM_DELAY;
            start_d = 1'b1;
            sel_d   = P_ARM;
          end
        end
        ARM_DELAY: begin
          if (ignition)      state_d = DISARMED;
          else if (door_any) state_d = DOOR_OPEN;
          else if (exp_ok)   state_d = ARMED;
        end
        default: state_d = ARMED;
      endcase
    end
  end

  // Next values of the registered outputs and the timer-live flag.
  always_comb begin
    live_d  = start_d || (live_q && (state_d == state_q) && !exp_ok);
    siren_d = (state_d == SOUND_ALARM) || (state_d == ALARM_HOLD);
    led_d   = 1'b0;
    if ((state_d == TRIGGERED) || siren_d) begin
      led_d = 1'b1;
    end else if ((state_d == ARMED) && (state_q == ARMED)) begin
      led_d = one_hz ? !led_q : led_q;
    end
    pump_d = ignition && (pump_q || (hidden_sw && brake));
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARMED;
      start_q <= 1'b0;
      value_q <= '0;
      siren_q <= 1'b0;
      led_q   <= 1'b0;
      pump_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      if (start_d) value_q <= sel_val;
      siren_q <= siren_d;
      led_q   <= led_d;
      pump_q  <= pump_d;
      live_q  <= live_d;
    end
  end

  assign start_timer = start_q;
  assign value       = value_q;
  assign siren       = siren_q;
  assign status_led  = led_q;
  assign fuel_pump   = pump_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_alarm_fsm.sv
// Bench for alarm_fsm: directed sequences with a start-value scoreboard.
module tb_alarm_fsm;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       ignition, door_driver, door_pass, hidden_sw, brake;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired_pulse, one_hz;
  logic       start_timer;
  logic [3:0] value;
  logic       siren, status_led, fuel_pump;
  logic [2:0] state_out;

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] exp_q [$];

  alarm_fsm dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ignition       (ignition),
    .door_driver    (door_driver),
    .door_pass      (door_pass),
    .hidden_sw      (hidden_sw),
    .brake          (brake),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .expired_pulse  (expired_pulse),
    .one_hz         (one_hz),
    .start_timer    (start_timer),
    .value          (value),
    .siren          (siren),
    .status_led     (status_led),
    .fuel_pump      (fuel_pump),
    .state_out      (state_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Every timer start is matched against the next expected interval.
  always @(negedge clock) begin
    if (start_timer) begin
      if (exp_q.size() == 0) check("start_unexpected", 32'(start_timer), 32'd0);
      else                   check("start_value", 32'(value), exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    ignition = 0; door_driver = 0; door_pass = 0; hidden_sw = 0; brake = 0;
    reprogram = 0; time_param_sel = 2'd0; time_value = 4'd0;
    expired_pulse = 0; one_hz = 0;
    step(); step();
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_start", 32'(start_timer), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_siren", 32'(siren), 32'd0);
    check("rst_led", 32'(status_led), 32'd0);
    check("rst_pump", 32'(fuel_pump), 32'd0);
    reset_n = 1'b1;
    step();

    // driver door while armed
    door_driver = 1; exp_q.push_back(32'd8); step();
    door_driver = 0;
    check("t1_state", 32'(state_out), 32'd1);
    check("t1_start", 32'(start_timer), 32'd1);
    check("t1_siren", 32'(siren), 32'd0);
    check("t1_led", 32'(status_led), 32'd1);
    step();
    check("t1_start_once", 32'(start_timer), 32'd0);

    // expiry -> siren, doors close -> hold, expiry -> armed
    door_pass = 1; expired_pulse = 1; step();
    expired_pulse = 0;
    check("t2_sound", 32'(state_out), 32'd2);
    check("t2_siren", 32'(siren), 32'd1);
    step();
    check("t2_sound_hold", 32'(state_out), 32'd2);
    door_pass = 0; exp_q.push_back(32'd10); step();
    check("t2_hold", 32'(state_out), 32'd3);
    check("t2_hold_siren", 32'(siren), 32'd1);
    step();
    expired_pulse = 1; step();
    expired_pulse = 0;
    check("t2_armed", 32'(state_out), 32'd0);
    check("t2_siren_off", 32'(siren), 32'd0);
    check("t2_led_off", 32'(status_led), 32'd0);

    // zero write clamps to 1; reprogram mid-count returns to armed
    reprogram = 1; time_param_sel = 2'd2; time_value = 4'd0; step();
    reprogram = 0;
    door_pass = 1; exp_q.push_back(32'd1); step();
    door_pass = 0;
    check("t3_trig_pas", 32'(state_out), 32'd1);
    step();
    reprogram = 1; time_param_sel = 2'd1; time_value = 4'd12; step();
    reprogram = 0;
    check("t3_reprog_state", 32'(state_out), 32'd0);
    check("t3_reprog_nostart", 32'(start_timer), 32'd0);
    door_driver = 1; exp_q.push_back(32'd12); step();
    door_driver = 0;
    check("t3_trig_drv", 32'(state_out), 32'd1);
    step();

    // ignition disarms; later expiry ignored
    ignition = 1; step();
    check("t4_disarmed", 32'(state_out), 32'd4);
    check("t4_nostart", 32'(start_timer), 32'd0);
    step();
    expired_pulse = 1; step();
    expired_pulse = 0;
    check("t4_stale_exp", 32'(state_out), 32'd4);
    check("t4_pump_off", 32'(fuel_pump), 32'd0);

    // door cycle -> arm delay, reopen, restart, expiry re-arms
    ignition = 0; door_driver = 1; step();
    check("t5_door_open", 32'(state_out), 32'd5);
    door_driver = 0; exp_q.push_back(32'd6); step();
    check("t5_arm_delay", 32'(state_out), 32'd6);
    step();
    door_driver = 1; step();
    check("t5_reopen", 32'(state_out), 32'd5);
    door_driver = 0; exp_q.push_back(32'd6); expired_pulse = 1; step();
    check("t5_restart", 32'(state_out), 32'd6);
    step();
    check("t5_exp_in_start", 32'(state_out), 32'd6);
    step();
    expired_pulse = 0;
    check("t5_armed", 32'(state_out), 32'd0);
    check("t5_led_entry", 32'(status_led), 32'd0);

    // LED blink in armed
    one_hz = 1; step();
    one_hz = 0;
    check("led_toggle_on", 32'(status_led), 32'd1);
    step();
    check("led_hold", 32'(status_led), 32'd1);
    one_hz = 1; step();
    one_hz = 0;
    check("led_toggle_off", 32'(status_led), 32'd0);

    // fuel pump latch
    ignition = 1; hidden_sw = 1; brake = 1; step();
    check("t6_pump_on", 32'(fuel_pump), 32'd1);
    check("t6_state_armed", 32'(state_out), 32'd0);
    hidden_sw = 0; brake = 0; step();
    check("t6_pump_held", 32'(fuel_pump), 32'd1);
    ignition = 0;
    check("t6_pump_pre", 32'(fuel_pump), 32'd1);
    step();
    check("t6_pump_clear", 32'(fuel_pump), 32'd0);

    // async reset in the middle of a start cycle
    ignition = 1; hidden_sw = 1; brake = 1; step();
    door_driver = 1; step();
    check("t6_mid_start", 32'(start_timer), 32'd1);
    check("t6_mid_value", 32'(value), 32'd12);
    check("t6_mid_pump", 32'(fuel_pump), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("t6_rst_state", 32'(state_out), 32'd0);
    check("t6_rst_start", 32'(start_timer), 32'd0);
    check("t6_rst_value", 32'(value), 32'd0);
    check("t6_rst_led", 32'(status_led), 32'd0);
    check("t6_rst_pump", 32'(fuel_pump), 32'd0);
    ignition = 0; hidden_sw = 0; brake = 0; door_driver = 0;
    step();
    reset_n = 1'b1;
    door_driver = 1; exp_q.push_back(32'd8); step();
    door_driver = 0;
    check("t6_param_default", 32'(state_out), 32'd1);
    step();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
